rv_mem_arb: RTL and testbench
=============================

Name: rv_mem_arb

Overview:
Shares the single-port unified memory between two requesters: the multicycle core (instruction fetch and load/store) and a debug/program-loader port. Sits between the core datapath/control and the memory. Sequences fixed-latency memory accesses with configurable wait states. Fairness is bounded so that neither requester starves.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
WAIT_CYC, 2, memory access cycles per transaction (legal range 1..15)
MAX_BURST, 4, max consecutive debug grants while a core request is pending (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
c_req  in  1  core request; held with stable c_we/c_addr/c_wdata until c_gnt
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_gnt  out  1  core grant, one-cycle pulse
c_rvalid  out  1  core completion, one-cycle pulse
c_rdata  out  DW  core read data, valid with c_rvalid
d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug request bundle, same rules as core
d_gnt, d_rvalid  out  1  debug grant / completion pulses
d_rdata  out  DW  debug read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid in the last ACCESS cycle
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. On reset, FSM goes to IDLE and every output is 0, including the data buses. Burst and wait counters are cleared.
- States: IDLE, ACCESS, RESP.
- IDLE with any request pending:
  - gnt is combinational, asserted in the same cycle to the selected requester.
  - On the next edge: latch owner, we, addr and wdata, then go to ACCESS.
- IDLE with no request: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Lasts exactly WAIT_CYC cycles, tracked by a down-counter.
  - In the last cycle, mem_rdata is registered into the owner's rdata; writes register 0 instead.
  - Then go to RESP.
- RESP: owner's rvalid=1 for one cycle, then go to IDLE. No grant is issued in ACCESS or RESP.
- Latency: gnt cycle T, mem_en cycles T+1..T+WAIT_CYC, rvalid at T+WAIT_CYC+1. One transaction per WAIT_CYC+2 cycles.
- rdata holds its value until that port's next completion. The non-owner's rvalid stays 0.
- Arbitration (evaluated only in IDLE):
  - Only one port requesting: grant it.
  - Both requesting: debug wins unless burst_cnt==MAX_BURST, in which case core wins.
  - burst_cnt increments on a debug grant while c_req=1; it saturates at MAX_BURST.
  - burst_cnt clears on any core grant, or on a debug grant with c_req=0.
- A requester that drops req before gnt is simply not served; no error is raised.
- Reset asserted mid-transaction: the transaction is aborted with no rvalid. After reset deasserts, the next request is served normally.

Optional Feature:
MEM_ARB_STATS_EN: when defined, adds three outputs:
- stall_cnt (16 bits): counts cycles with c_req=1 and c_gnt=0.
- c_gnt_cnt (16 bits): counts core grants.
- d_gnt_cnt (16 bits): counts debug grants.
All three are saturating at 0xFFFF and cleared by rst. When the macro is undefined, these ports and their logic do not exist and the behaviour above is unchanged.

Test Plan:
1. Core read, WAIT_CYC=2: c_req at cycle 0, addr 0x10, mem_rdata=0xDEADBEEF -> c_gnt at cycle 0; mem_en=1 with mem_addr=0x10 in cycles 1-2; c_rvalid at cycle 3 with c_rdata=0xDEADBEEF; busy=1 in cycles 1-3.
2. Core write, addr 0x20, data 0x00001234 -> mem_en=mem_we=1 in cycles 1-2 with that addr/data; c_rvalid pulse with c_rdata=0; d_rvalid stays 0.
3. Simultaneous single requests from c and d -> d_gnt at cycle 0; c_gnt at cycle 4 (the next IDLE); c_rvalid at cycle 7.
4. MAX_BURST=4, c_req and d_req both held continuously -> grant order d,d,d,d,c,d,d,d,d,c; no cycle has both gnt outputs high.
5. rst pulsed at the second ACCESS cycle of a debug read -> all outputs 0 immediately; no d_rvalid; a subsequent core read of 0x10 completes per scenario 1.
6. MEM_ARB_STATS_EN defined, run scenario 3 -> stall_cnt=4, c_gnt_cnt=1, d_gnt_cnt=1.

Source files
------------

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one fixed-latency single-port memory between the core and a debug/loader port.
// Define MEM_ARB_STATS_EN to add the stall_cnt / c_gnt_cnt / d_gnt_cnt statistics outputs.
module rv_mem_arb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int WAIT_CYC  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  // Handshake: a requester raises x_req with a stable bundle and holds it until x_gnt;
  // x_gnt is a combinational one-cycle pulse in IDLE, x_rvalid pulses once WAIT_CYC+1 cycles later.
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]   stall_cnt,
  output logic [15:0]   c_gnt_cnt,
  output logic [15:0]   d_gnt_cnt,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = debug owns the current transaction
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]    wait_q, wait_d;
  logic [3:0]    burst_q, burst_d;
  logic          arb_open;
  logic          core_wins;

  // Grants are masked while rst is high so every output reads 0 during reset.
  assign arb_open  = (state_q == S_IDLE) && !rst;
  assign core_wins = c_req && (!d_req || (burst_q == BURST_MAX));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    wait_d    = wait_q;
    burst_d   = burst_q;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_open && core_wins) begin
          c_gnt   = 1'b1;
          owner_d = 1'b0;
          we_d    = c_we;
          addr_d  = c_addr;
          wdata_d = c_wdata;
          burst_d = '0;
          wait_d  = WAIT_LOAD;
          state_d = S_ACCESS;
        end else if (arb_open && d_req) begin
          d_gnt   = 1'b1;
          owner_d = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wait_d  = WAIT_LOAD;
          state_d = S_ACCESS;
          // Only debug wins taken while the core waits count toward the burst limit.
          if (!c_req) begin
            burst_d = '0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + 4'd1;
          end
        end
      end
      S_ACCESS: begin
        if (wait_q == '0) begin
          state_d = S_RESP;
          if (owner_q) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            c_rdata_d = we_q ? '0 : mem_rdata;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      wait_q    <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      wait_q    <= wait_d;
      burst_q   <= burst_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign c_rvalid  = (state_q == S_RESP) && !owner_q;
  assign d_rvalid  = (state_q == S_RESP) && owner_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] c_gnt_cnt_q, c_gnt_cnt_d;
  logic [15:0] d_gnt_cnt_q, d_gnt_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    c_gnt_cnt_d = c_gnt_cnt_q;
    d_gnt_cnt_d = d_gnt_cnt_q;
    if (c_req && !c_gnt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (c_gnt && (c_gnt_cnt_q != 16'hFFFF))           c_gnt_cnt_d = c_gnt_cnt_q + 16'd1;
    if (d_gnt && (d_gnt_cnt_q != 16'hFFFF))           d_gnt_cnt_d = d_gnt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      c_gnt_cnt_q <= '0;
      d_gnt_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      c_gnt_cnt_q <= c_gnt_cnt_d;
      d_gnt_cnt_q <= d_gnt_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign c_gnt_cnt = c_gnt_cnt_q;
  assign d_gnt_cnt = d_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: directed scenarios plus random two-port traffic against a timing-rule reference model.
// Build with MEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_rv_mem_arb;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int WAIT_CYC  = 2;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   stall_cnt, c_gnt_cnt, d_gnt_cnt;
`endif

  always #5 clk = ~clk;

  rv_mem_arb #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .stall_cnt(stall_cnt), .c_gnt_cnt(c_gnt_cnt), .d_gnt_cnt(d_gnt_cnt),
`endif
    .busy(busy)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return DW'(a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction
  assign mem_rdata = mem_fn(mem_addr);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (latency rules) ----------------
  int            t_gnt = -100;  // cycle of the most recent grant
  bit            m_owner_d;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            d_streak = 0;  // debug wins in a row while the core was waiting
  logic [DW-1:0] c_last = '0, d_last = '0;
  logic [DW-1:0] c_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  bit            m_cg, m_dg;
  bit            gnt_log[$];
  int            m_stall = 0, m_cg_cnt = 0, m_dg_cnt = 0;

  task automatic model_reset();
    t_gnt = -100;
    d_streak = 0;
    c_last = '0;
    d_last = '0;
    c_exp_q.delete();
    d_exp_q.delete();
    m_stall = 0;
    m_cg_cnt = 0;
    m_dg_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c_gnt"}, c_gnt, 0);
    check({tag, "_d_gnt"}, d_gnt, 0);
    check({tag, "_c_rvalid"}, c_rvalid, 0);
    check({tag, "_d_rvalid"}, d_rvalid, 0);
    check({tag, "_c_rdata"}, c_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef MEM_ARB_STATS_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
    check({tag, "_c_gnt_cnt"}, c_gnt_cnt, 0);
    check({tag, "_d_gnt_cnt"}, d_gnt_cnt, 0);
`endif
  endtask

  // Called at the negedge: compare every output, then advance the model past this cycle.
  task automatic check_cycle();
    bit idle, in_acc, in_resp;
    idle    = (cyc >= t_gnt + WAIT_CYC + 2);
    in_acc  = (cyc >= t_gnt + 1) && (cyc <= t_gnt + WAIT_CYC);
    in_resp = (cyc == t_gnt + WAIT_CYC + 1);
    m_cg = idle && c_req && (!d_req || d_streak >= MAX_BURST);
    m_dg = idle && d_req && !m_cg;

    check("c_gnt", c_gnt, m_cg);
    check("d_gnt", d_gnt, m_dg);
    check("both_gnt", c_gnt & d_gnt, 0);
    check("busy", busy, !idle);
    check("mem_en", mem_en, in_acc);
    check("mem_we", mem_we, in_acc && m_we);
    check("mem_addr", mem_addr, in_acc ? m_addr : '0);
    check("mem_wdata", mem_wdata, in_acc ? m_wdata : '0);

    if (in_resp) begin
      if (!m_owner_d) begin
        if (c_exp_q.size() == 0) check("c_exp_q_nonempty", 0, 1);
        else c_last = c_exp_q.pop_front();
      end else begin
        if (d_exp_q.size() == 0) check("d_exp_q_nonempty", 0, 1);
        else d_last = d_exp_q.pop_front();
      end
    end
    check("c_rvalid", c_rvalid, in_resp && !m_owner_d);
    check("d_rvalid", d_rvalid, in_resp && m_owner_d);
    check("c_rdata", c_rdata, c_last);
    check("d_rdata", d_rdata, d_last);

`ifdef MEM_ARB_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("c_gnt_cnt", c_gnt_cnt, m_cg_cnt);
    check("d_gnt_cnt", d_gnt_cnt, m_dg_cnt);
`endif
    if (c_req && !m_cg) m_stall++;
    if (m_cg) m_cg_cnt++;
    if (m_dg) m_dg_cnt++;

    if (m_cg || m_dg) begin
      t_gnt     = cyc;
      m_owner_d = m_dg;
      m_we      = m_cg ? c_we : d_we;
      m_addr    = m_cg ? c_addr : d_addr;
      m_wdata   = m_cg ? c_wdata : d_wdata;
      if (m_cg) c_exp_q.push_back(m_we ? '0 : mem_fn(m_addr));
      else      d_exp_q.push_back(m_we ? '0 : mem_fn(m_addr));
      gnt_log.push_back(m_dg);
      if (m_cg)       d_streak = 0;
      else if (c_req) d_streak = (d_streak < MAX_BURST) ? d_streak + 1 : MAX_BURST;
      else            d_streak = 0;
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: check at the negedge, then retire granted requests just after the posedge.
  task automatic run_cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (m_cg) c_req = 1'b0;
    if (m_dg) d_req = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic core_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic dbg_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // Assert rst mid-cycle, check outputs clear at once, release after the next posedge.
  task automatic reset_mid(input string tag);
    #2 rst = 1'b1;
    c_req = 1'b0;
    d_req = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 32'h10;
    return AW'($urandom_range(0, 1023)) << 2;
  endfunction

  task automatic rand_drive();
    if (!c_req) begin
      if ($urandom_range(0, 2) == 0) core_req(1'($urandom_range(0, 1)), pick_addr(), $urandom());
    end else if ($urandom_range(0, 30) == 0) begin
      c_req = 1'b0;
    end
    if (!d_req) begin
      if ($urandom_range(0, 2) == 0) dbg_req(1'($urandom_range(0, 1)), pick_addr(), $urandom());
    end else if ($urandom_range(0, 30) == 0) begin
      d_req = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`ifdef MEM_ARB_STATS_EN
    int s_stall, s_cg, s_dg;
`endif
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_reset();
    rst = 1'b0;

    // Core read of 0x10
    core_req(1'b0, 32'h10, '0);
    run_cycles(5);
    check("s1_c_rdata", c_rdata, 32'hDEADBEEF);

    // Core write
    core_req(1'b1, 32'h20, 32'h0000_1234);
    run_cycles(5);
    check("s2_c_rdata", c_rdata, 0);
    check("s2_d_rdata", d_rdata, 0);

    // Simultaneous single requests: debug first, core at the next IDLE
`ifdef MEM_ARB_STATS_EN
    s_stall = int'(stall_cnt); s_cg = int'(c_gnt_cnt); s_dg = int'(d_gnt_cnt);
`endif
    gnt_log.delete();
    core_req(1'b0, 32'h40, '0);
    dbg_req(1'b0, 32'h44, '0);
    run_cycles(9);
    check("s3_n_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("s3_first_debug", gnt_log[0], 1);
      check("s3_second_core", gnt_log[1], 0);
    end
    check("s3_c_rdata", c_rdata, mem_fn(32'h40));
    check("s3_d_rdata", d_rdata, mem_fn(32'h44));
`ifdef MEM_ARB_STATS_EN
    check("s6_stall_delta", int'(stall_cnt) - s_stall, 4);
    check("s6_c_gnt_delta", int'(c_gnt_cnt) - s_cg, 1);
    check("s6_d_gnt_delta", int'(d_gnt_cnt) - s_dg, 1);
`endif

    // Both requesters held continuously: burst limit forces every fifth grant to the core
    gnt_log.delete();
    for (int i = 0; i < 10 * (WAIT_CYC + 2); i++) begin
      if (!c_req) core_req(1'b0, 32'h100 + AW'(i * 4), '0);
      if (!d_req) dbg_req(1'b1, 32'h200 + AW'(i * 4), DW'(i));
      run_cycle();
    end
    c_req = 1'b0;
    d_req = 1'b0;
    run_cycles(WAIT_CYC + 2);
    check("s4_n_grants", gnt_log.size(), 10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++) begin
      check($sformatf("s4_order_%0d", i), gnt_log[i], exp_order[i]);
    end

    // Reset during the second ACCESS cycle of a debug read
    dbg_req(1'b0, 32'h80, '0);
    run_cycles(2);
    reset_mid("s5_mid_reset");
    run_cycles(3);
    core_req(1'b0, 32'h10, '0);
    run_cycles(5);
    check("s5_c_rdata", c_rdata, 32'hDEADBEEF);
    check("s5_d_rdata", d_rdata, 0);

    // Random two-port traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      if ($urandom_range(0, 499) == 0) reset_mid("rand_reset");
      else run_cycle();
    end
    c_req = 1'b0;
    d_req = 1'b0;
    run_cycles(WAIT_CYC + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
